// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared state encoding and buffer occupancy width for the FIFO read-side stream.
package fifo_rd_stream_pkg;
    typedef enum logic {STREAM = 1'b0, FLUSH = 1'b1} state_t;
    localparam int OCC_W = 2;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry skid buffer with push/pop/clear; head is always the oldest word.
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int datawidth = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic [datawidth-1:0] din,
    output logic [OCC_W-1:0]     occ,
    output logic [datawidth-1:0] head
);
    logic [datawidth-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= '0;
            head <= '0;
            tail <= '0;
        end else if (clear) begin
            occ <= '0;
        end else if (push && !pop) begin
            if (occ == '0) head <= din;
            else tail <= din;
            occ <= occ + 1'b1;
        end else if (pop && !push) begin
            head <= tail;
            occ  <= occ - 1'b1;
        end else if (push && pop) begin
            head <= (occ == 2'd2) ? tail : din;
            if (occ == 2'd2) tail <= din;
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the async FIFO read port into a valid/ready stream with flush and a delivered-word count.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int datawidth = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [datawidth-1:0] rdata,
    input  logic                 rempty,
    output logic                 rinc,
    output logic [datawidth-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    input  logic                 flush,
    output logic                 flush_busy,
    output logic [cnt_width-1:0] word_count
);
    state_t           state, state_nxt;
    logic [OCC_W-1:0] occ;
    logic             push, pop, clear;

    fifo_skid_buf #(.datawidth(datawidth)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (rdata),
        .occ   (occ),
        .head  (m_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STREAM;
            word_count <= '0;
        end else begin
            state <= state_nxt;
            if (pop) word_count <= word_count + 1'b1;
        end
    end

    // In FLUSH the FIFO is drained without touching the buffer.
    always_comb begin
        state_nxt = state;
        rinc      = 1'b0;
        clear     = 1'b0;
        if (state == STREAM) begin
            rinc  = !rempty && occ < 2'd2 && !flush;
            clear = flush;
            if (flush) state_nxt = FLUSH;
        end else begin
            rinc = !rempty;
            if (rempty && !flush) state_nxt = STREAM;
        end
        if (rst) rinc = 1'b0;
    end

    assign push       = state == STREAM && rinc;
    assign m_valid    = state == STREAM && occ != '0;
    assign pop        = m_valid && m_ready;
    assign flush_busy = state == FLUSH;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of streaming, backpressure, flush, count wrap and mid-stream reset.
module tb_fifo_rd_stream;
    logic       clk = 1'b0;
    logic       rst, rempty, rinc, m_valid, m_ready, flush, flush_busy;
    logic [7:0] rdata, m_data;
    logic [3:0] word_count;
    logic [7:0] mem [64];
    logic [5:0] wr_ptr = '0, rd_ptr = '0;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.datawidth(8), .cnt_width(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdata      (rdata),
        .rempty     (rempty),
        .rinc       (rinc),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .flush      (flush),
        .flush_busy (flush_busy),
        .word_count (word_count)
    );

    // FIFO read-port model: first-word-fall-through, popped by rinc
    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr];
    always @(posedge clk) if (rinc && !rempty) rd_ptr <= rd_ptr + 1'b1;

    task automatic push_word(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; m_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h11 + 8'(i));
        for (int i = 0; i < 2; i++) begin
            tick; #1;
            chk("rst_rinc", rinc, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_data", m_data, 0);
            chk("rst_count", word_count, 0);
            chk("rst_busy", flush_busy, 0);
        end
        rst = 1'b0; #1;
        chk("st_first_rinc", rinc, 1);
        chk("st_first_valid", m_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick; #1;
            chk("st_valid", m_valid, 1);
            chk("st_data", m_data, 32'h11 + 32'(i));
            chk("st_count", word_count, i);
            chk("st_rinc", rinc, (i < 7) ? 1 : 0);
        end
        tick;
        m_ready = 1'b0;
        push_word(8'h11); push_word(8'h12); push_word(8'h13);
        #1;
        chk("st_end_valid", m_valid, 0);
        chk("st_end_count", word_count, 8);
        chk("bp_rinc0", rinc, 1);
        tick; #1;
        chk("bp_data1", m_data, 8'h11);
        chk("bp_rinc1", rinc, 1);
        tick; #1;
        chk("bp_full_rinc", rinc, 0);
        chk("bp_hold_data", m_data, 8'h11);
        tick;
        m_ready = 1'b1; #1;
        chk("bp_hold2_data", m_data, 8'h11);
        chk("bp_hold2_valid", m_valid, 1);
        chk("bp_hold2_rinc", rinc, 0);
        chk("bp_hold2_count", word_count, 8);
        tick; #1;
        chk("bp_d2", m_data, 8'h12);
        chk("bp_d2_rinc", rinc, 1);
        chk("bp_d2_count", word_count, 9);
        tick; #1;
        chk("bp_d3", m_data, 8'h13);
        chk("bp_d3_valid", m_valid, 1);
        tick;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'h21 + 8'(i));
        #1;
        chk("bp_end_valid", m_valid, 0);
        chk("bp_end_count", word_count, 11);
        tick; tick;
        flush = 1'b1; #1;
        chk("fl_pre_data", m_data, 8'h21);
        chk("fl_pre_valid", m_valid, 1);
        chk("fl_pre_rinc", rinc, 0);
        tick;
        flush = 1'b0; #1;
        chk("fl_busy", flush_busy, 1);
        chk("fl_valid", m_valid, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin tick; #1; end
            chk("fl_rinc", rinc, 1);
            chk("fl_drain_valid", m_valid, 0);
        end
        tick; #1;
        chk("fl_empty_busy", flush_busy, 1);
        chk("fl_empty_rinc", rinc, 0);
        chk("fl_count", word_count, 11);
        tick;
        m_ready = 1'b1;
        push_word(8'h30); #1;
        chk("fl_exit_busy", flush_busy, 0);
        chk("fl_exit_rinc", rinc, 1);
        tick; #1;
        chk("fl_next_data", m_data, 8'h30);
        chk("fl_next_valid", m_valid, 1);
        tick;
        m_ready = 1'b0;
        push_word(8'h41); push_word(8'h42); #1;
        chk("fl_next_count", word_count, 12);
        tick; tick;
        m_ready = 1'b1; flush = 1'b1; #1;
        chk("sim_data", m_data, 8'h41);
        chk("sim_valid", m_valid, 1);
        tick;
        flush = 1'b0; #1;
        chk("sim_count", word_count, 13);
        chk("sim_busy", flush_busy, 1);
        chk("sim_valid_off", m_valid, 0);
        tick;
        for (int i = 0; i < 4; i++) push_word(8'h50 + 8'(i));
        #1;
        chk("sim_exit_busy", flush_busy, 0);
        chk("sim_exit_count", word_count, 13);
        for (int i = 0; i < 4; i++) begin
            tick; #1;
            chk("wr_data", m_data, 32'h50 + 32'(i));
            chk("wr_count", word_count, (13 + i) % 16);
        end
        tick;
        m_ready = 1'b0;
        push_word(8'h61); push_word(8'h62); push_word(8'h63); #1;
        chk("wr_wrapped_count", word_count, 1);
        chk("wr_wrapped_valid", m_valid, 0);
        tick; tick;
        rst = 1'b1; #1;
        chk("mr_full_data", m_data, 8'h61);
        chk("mr_full_valid", m_valid, 1);
        chk("mr_rst_rinc", rinc, 0);
        tick; #1;
        chk("mr_valid", m_valid, 0);
        chk("mr_data", m_data, 0);
        chk("mr_count", word_count, 0);
        chk("mr_rinc", rinc, 0);
        tick;
        rst = 1'b0; #1;
        chk("mr_rel_rinc", rinc, 1);
        chk("mr_rel_valid", m_valid, 0);
        tick; #1;
        chk("mr_next_data", m_data, 8'h63);
        chk("mr_next_count", word_count, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
